psum_accum_unit: RTL and testbench
==================================

PSUM_ACCUM_UNIT -- requirements
Module: psum_accum_unit

Interface
REQ-001 Parameter PSUM_W, default 20: width of each signed product.
REQ-002 Parameter ACC_W, default 32: width of the signed accumulator and output sum.
REQ-003 Parameter LEN_W, default 8: width of the accumulation-length input.
REQ-004 s_clk  in  1  clock, rising edge; s_rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle pulse that latches acc_len and begins a dot product.
REQ-006 acc_len  in  LEN_W  number of products per sum; 0 is treated as 1.
REQ-007 prod  in  PSUM_W  signed product from the multiplier stage.
REQ-008 prod_vld  in  1  qualifies prod; no backpressure upstream.
REQ-009 sum  out  ACC_W  signed accumulated result, head of output FIFO.
REQ-010 sum_vld  out  1  sum is valid; sum_rdy  in  1  consumer accepts.
REQ-011 busy  out  1  high in ACCUM state.
REQ-012 ovf_err  out  1  sticky: a result was dropped due to full FIFO.
REQ-013 sat_flag  out  1  sticky: at least one sum saturated since reset.

Function
REQ-014 FSM states IDLE and ACCUM; IDLE -> ACCUM on start; ACCUM -> IDLE on the cycle the final product is absorbed.
REQ-015 start in ACCUM shall abort the current sum, discard the partial accumulator and restart with the new acc_len.
REQ-016 prod_vld in IDLE shall be ignored.
REQ-017 On start, acc = 0, cnt = 0, len = max(acc_len,1).
REQ-018 Each prod_vld in ACCUM: acc <= sat(acc + sign_extend(prod)), cnt <= cnt + 1.
REQ-019 Saturation: clamp to +(2^(ACC_W-1))-1 / -(2^(ACC_W-1)) on overflow, and set sat_flag.
REQ-020 When prod_vld arrives with cnt == len-1, the final value (including this product) shall be written to the FIFO on the next edge.
REQ-021 Latency: final prod_vld at cycle N -> sum_vld high at cycle N+1 when the FIFO was empty.
REQ-022 Output FIFO depth 2, first-word fall-through; entry pops on sum_vld & sum_rdy.
REQ-023 Simultaneous push and pop when full: both occur, and no ovf_err is raised.
REQ-024 Push while full without a pop: the result is dropped, FIFO contents are unchanged, and ovf_err is set.
REQ-025 sum and sum_vld shall be stable while sum_vld & !sum_rdy.
REQ-026 Back-to-back start immediately after completion shall lose no cycles: a product on the cycle after start is accumulated.

Reset
REQ-027 s_rst asserted: FSM = IDLE, acc = 0, cnt = 0, FIFO empty.
REQ-028 During s_rst, outputs are: sum = 0, sum_vld = 0, busy = 0, ovf_err = 0, sat_flag = 0.
REQ-029 Reset mid-ACCUM discards the partial sum, and no sum_vld follows after deassertion.
REQ-030 Sticky flags shall clear only on s_rst.

Verification
REQ-031 start, acc_len = 4, prods 3, -5, 7, 10 on consecutive cycles, sum_rdy = 1 -> sum = 15 with a one-cycle sum_vld, one cycle after the last product.
REQ-032 acc_len = 0, one prod = -9 -> sum = -9 and busy for exactly one accepted product.
REQ-033 ACC_W = 8, acc_len = 3, prods 100, 100, 100 -> sum = 127, sat_flag = 1.
REQ-034 sum_rdy = 0, three complete sums 1, 2, 3 (acc_len = 1) -> FIFO holds 1, 2, ovf_err = 1; raise sum_rdy -> sums 1, 2 are popped in order, then sum_vld = 0.
REQ-035 start, two prods, then s_rst pulse, then prods -> no sum_vld, busy = 0.
REQ-036 start, acc_len = 4, two prods of 5, second start with acc_len = 2, prods 1, 1 -> single sum = 2.

Source files
------------

// File: rtl/psum_accum_unit.sv
// Partial-sum accumulator: adds a run of signed products with saturation and
// queues each finished dot product in a two-entry fall-through output FIFO.
module psum_accum_unit #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic [PSUM_W-1:0] prod,
    input  logic              prod_vld,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_vld,
    input  logic              sum_rdy,
    output logic              busy,
    output logic              ovf_err,
    output logic              sat_flag
);

    // One guard bit above the wider operand so the raw sum never wraps.
    localparam int EXT_W = ((ACC_W > PSUM_W) ? ACC_W : PSUM_W) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic [ACC_W-1:0]   mem_q [2];
    logic [1:0]         wr_en;

    logic [EXT_W-1:0]       acc_ext;
    logic [EXT_W-1:0]       prod_ext;
    logic [EXT_W-1:0]       add_ext;
    logic [EXT_W-ACC_W:0]   add_top;
    logic                   add_ovf;
    logic [ACC_W-1:0]       add_sat;
    logic [LEN_W-1:0]       len_sel;
    logic                   last_prod;
    logic                   absorb;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   do_push;

    // Saturating adder: overflow shows up as disagreement among the bits
    // from the result sign position up to the guard bit.
    assign acc_ext  = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign prod_ext = {{(EXT_W-PSUM_W){prod[PSUM_W-1]}}, prod};
    assign add_ext  = acc_ext + prod_ext;
    assign add_top  = add_ext[EXT_W-1:ACC_W-1];
    assign add_ovf  = !((&add_top) || !(|add_top));

    always_comb begin
        add_sat = add_ext[ACC_W-1:0];
        if (add_ovf) begin
            if (add_ext[EXT_W-1]) begin
                add_sat = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                add_sat = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    assign len_sel   = (acc_len == '0) ? LEN_W'(1) : acc_len;
    assign last_prod = (cnt_q == (len_q - LEN_W'(1)));
    assign absorb    = (state_q == ACCUM) && prod_vld && !start;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sat_d   = sat_q;
        push    = 1'b0;
        if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            len_d   = len_sel;
        end else if (absorb) begin
            sat_d = sat_q | add_ovf;
            if (last_prod) begin
                push    = 1'b1;
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = add_sat;
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    // A full FIFO can still take a result if the head leaves on the same edge.
    assign sum_vld = (count_q != 2'd0);
    assign pop     = sum_vld && sum_rdy;
    assign full    = (count_q == 2'd2);
    assign do_push = push && (!full || pop);

    always_comb begin
        ovf_d    = ovf_q | (push && full && !pop);
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        count_d  = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_q == 1'(gi));
        end
    endgenerate

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            len_q    <= LEN_W'(1);
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i]) begin
                    mem_q[i] <= add_sat;
                end
            end
        end
    end

    assign sum      = mem_q[rd_ptr_q];
    assign busy     = (state_q == ACCUM);
    assign ovf_err  = ovf_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_psum_accum_unit.sv
// Directed bench for psum_accum_unit: a 32-bit and an 8-bit accumulator share
// stimulus and are both checked every cycle against a queue-level model.
module tb_psum_accum_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  acc_len;
    logic [19:0] prod;
    logic        prod_vld;
    logic        sum_rdy;

    logic [31:0] sum32;
    logic        vld32, busy32, ovf32, sat32;
    logic [7:0]  sum8;
    logic        vld8, busy8, ovf8, sat8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_accum_unit u_dut32 (
        .s_clk(clk), .s_rst(rst), .start(start), .acc_len(acc_len),
        .prod(prod), .prod_vld(prod_vld), .sum(sum32), .sum_vld(vld32),
        .sum_rdy(sum_rdy), .busy(busy32), .ovf_err(ovf32), .sat_flag(sat32)
    );

    psum_accum_unit #(.ACC_W(8)) u_dut8 (
        .s_clk(clk), .s_rst(rst), .start(start), .acc_len(acc_len),
        .prod(prod), .prod_vld(prod_vld), .sum(sum8), .sum_vld(vld8),
        .sum_rdy(sum_rdy), .busy(busy8), .ovf_err(ovf8), .sat_flag(sat8)
    );

    // Model: index 0 is the 32-bit unit, index 1 the 8-bit unit.
    bit     m_act  [2];
    longint m_acc  [2];
    int     m_cnt  [2];
    int     m_len  [2];
    longint m_fifo [2][2];
    int     m_n    [2];
    bit     m_ovf  [2];
    bit     m_sat  [2];

    always @(posedge clk or posedge rst) begin
        bit     fin;
        longint fv;
        longint mx;
        longint mn;
        for (int i = 0; i < 2; i++) begin
            mx = (i == 0) ? 64'sd2147483647 : 64'sd127;
            mn = -mx - 1;
            if (rst) begin
                m_act[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_len[i] = 1;
                m_n[i] = 0; m_ovf[i] = 0; m_sat[i] = 0;
                m_fifo[i][0] = 0; m_fifo[i][1] = 0;
            end else begin
                fin = 0;
                fv  = 0;
                if (start) begin
                    m_act[i] = 1;
                    m_acc[i] = 0;
                    m_cnt[i] = 0;
                    m_len[i] = (acc_len == 0) ? 1 : int'(acc_len);
                end else if (m_act[i] && prod_vld) begin
                    m_acc[i] = m_acc[i] + longint'($signed(prod));
                    if (m_acc[i] > mx) begin m_acc[i] = mx; m_sat[i] = 1; end
                    if (m_acc[i] < mn) begin m_acc[i] = mn; m_sat[i] = 1; end
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == m_len[i]) begin
                        fin = 1;
                        fv = m_acc[i];
                        m_act[i] = 0;
                    end
                end
                if (m_n[i] > 0 && sum_rdy) begin
                    m_fifo[i][0] = m_fifo[i][1];
                    m_n[i] = m_n[i] - 1;
                end
                if (fin) begin
                    if (m_n[i] < 2) begin
                        m_fifo[i][m_n[i]] = fv;
                        m_n[i] = m_n[i] + 1;
                    end else begin
                        m_ovf[i] = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("m32_vld",  longint'(vld32),  longint'(m_n[0] > 0));
        chk("m32_busy", longint'(busy32), longint'(m_act[0]));
        chk("m32_ovf",  longint'(ovf32),  longint'(m_ovf[0]));
        chk("m32_sat",  longint'(sat32),  longint'(m_sat[0]));
        if (m_n[0] > 0 || rst) chk("m32_sum", longint'($signed(sum32)), m_fifo[0][0]);
        chk("m8_vld",   longint'(vld8),   longint'(m_n[1] > 0));
        chk("m8_busy",  longint'(busy8),  longint'(m_act[1]));
        chk("m8_ovf",   longint'(ovf8),   longint'(m_ovf[1]));
        chk("m8_sat",   longint'(sat8),   longint'(m_sat[1]));
        if (m_n[1] > 0 || rst) chk("m8_sum", longint'($signed(sum8)), m_fifo[1][0]);
    endtask

    // Compare against the model mid-cycle, then step past the next edge.
    task automatic tick();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start = 1'b1; acc_len = 8'(len); prod_vld = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_prod(input int val);
        prod = 20'(val); prod_vld = 1'b1;
        tick();
        prod_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        prod_vld = 1'b0; start = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; acc_len = 8'd0; prod = 20'd0;
        prod_vld = 1'b0; sum_rdy = 1'b1;
        tick(); tick();
        chk("rst_sum", longint'(sum32), 0);
        chk("rst_vld", longint'(vld32), 0);
        chk("rst_busy", longint'(busy32), 0);
        chk("rst_flags", longint'({ovf32, sat32}), 0);
        rst = 1'b0;
        tick();

        // Products while idle are ignored.
        for (int k = 0; k < 3; k++) do_prod(50);
        chk("idle_vld", longint'(vld32), 0);

        // 3 - 5 + 7 + 10 = 15, one cycle after the last product.
        do_start(4);
        chk("t1_busy", longint'(busy32), 1);
        do_prod(3); do_prod(-5); do_prod(7);
        chk("t1_novld", longint'(vld32), 0);
        do_prod(10);
        chk("t1_vld", longint'(vld32), 1);
        chk("t1_sum", longint'($signed(sum32)), 15);
        chk("t1_busy_end", longint'(busy32), 0);
        idle(1);
        chk("t1_pulse", longint'(vld32), 0);

        // Length 0 behaves as length 1.
        do_start(0);
        chk("t2_busy", longint'(busy32), 1);
        do_prod(-9);
        chk("t2_sum", longint'($signed(sum32)), -9);
        chk("t2_busy_end", longint'(busy32), 0);
        idle(1);

        // 300 saturates the 8-bit unit to 127.
        do_start(3);
        do_prod(100); do_prod(100); do_prod(100);
        chk("t3_sum8", longint'($signed(sum8)), 127);
        chk("t3_sat8", longint'(sat8), 1);
        chk("t3_sum32", longint'($signed(sum32)), 300);
        chk("t3_sat32", longint'(sat32), 0);
        idle(1);

        // Stalled consumer: third result dropped, then drain in order.
        sum_rdy = 1'b0;
        do_start(1); do_prod(1);
        do_start(1); do_prod(2);
        do_start(1); do_prod(3);
        idle(2);
        chk("t4_ovf", longint'(ovf32), 1);
        chk("t4_head", longint'($signed(sum32)), 1);
        sum_rdy = 1'b1;
        tick();
        chk("t4_second", longint'($signed(sum32)), 2);
        chk("t4_second_vld", longint'(vld32), 1);
        tick();
        chk("t4_empty", longint'(vld32), 0);

        // Reset mid-accumulation discards everything and clears sticky flags.
        do_start(4); do_prod(1); do_prod(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_prod(3); do_prod(4);
        idle(2);
        chk("t5_vld", longint'(vld32), 0);
        chk("t5_busy", longint'(busy32), 0);
        chk("t5_ovf", longint'(ovf32), 0);
        chk("t5_sat8", longint'(sat8), 0);

        // Restart aborts the partial sum; then an immediate back-to-back run.
        do_start(4); do_prod(5); do_prod(5);
        do_start(2); do_prod(1); do_prod(1);
        chk("t6_sum", longint'($signed(sum32)), 2);
        do_start(2);
        chk("t6_single", longint'(vld32), 0);
        do_prod(4); do_prod(6);
        chk("t6_b2b", longint'($signed(sum32)), 10);
        idle(1);

        // Push and pop on the same edge while full: no drop, no error.
        sum_rdy = 1'b0;
        do_start(1); do_prod(7);
        do_start(1); do_prod(8);
        do_start(1);
        sum_rdy = 1'b1;
        do_prod(9);
        chk("t7_head", longint'($signed(sum32)), 8);
        chk("t7_ovf", longint'(ovf32), 0);
        tick();
        chk("t7_tail", longint'($signed(sum32)), 9);
        tick();
        chk("t7_empty", longint'(vld32), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
